// File: rtl/arith_pkg.sv
// Shared arithmetic-lab definitions: divider FSM states, default widths and
// the step-counter width helper.
package arith_pkg;

    localparam int DEF_DIVIDEND_W = 6;
    localparam int DEF_DIVISOR_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    function automatic int cnt_width(input int dividend_w);
        return $clog2(dividend_w) + 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_DIVIDEND_W);

endpackage

// File: rtl/signed_sequential_divider_if.sv
// Start/busy/done handshake plus operand and result bundle of the divider.
interface signed_sequential_divider_if
    import arith_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) ();
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
    logic                  overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/signed_sequential_divider_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step
    import arith_pkg::*;
#(
    parameter int DIVISOR_W = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W:0] rem,
    input  logic               next_bit,
    input  logic [DIVISOR_W:0] dmag,
    output logic [DIVISOR_W:0] rem_out,
    output logic               q_bit
);
    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] diff;

    // One guard bit above the shifted remainder makes the trial sign exact.
    assign shifted = {rem, next_bit};
    assign diff    = shifted - {1'b0, dmag};
    assign q_bit   = ~diff[DIVISOR_W+1];
    assign rem_out = (DIVISOR_W+1)'(q_bit ? diff : shifted);
endmodule

// File: rtl/signed_sequential_divider.sv
// Iterative signed divider: restoring division on magnitudes, one quotient bit
// per clock, then a sign fix-up stage before the done pulse.
module signed_sequential_divider
    import arith_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    signed_sequential_divider_if.slave   bus
);
    localparam int CW = cnt_width(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] Q_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};

    div_state_t            state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [DIVIDEND_W:0]   dvd_reg, dvd_next;
    logic [DIVISOR_W:0]    dmag_reg, dmag_next;
    logic [DIVISOR_W:0]    prem_reg, prem_next;
    logic                  sign_q_reg, sign_q_next;
    logic                  sign_r_reg, sign_r_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic [DIVIDEND_W-1:0] quot_reg, quot_next;
    logic [DIVISOR_W-1:0]  rem_reg, rem_next;
    logic                  dbz_reg, dbz_next;
    logic                  ovf_reg, ovf_next;

    logic [DIVIDEND_W:0]   dvd_ext;
    logic [DIVISOR_W:0]    dsr_ext;
    logic [DIVISOR_W:0]    step_rem;
    logic                  step_q;
    logic [DIVIDEND_W-1:0] qmag;
    logic [DIVISOR_W-1:0]  rmag;

    // The extra magnitude bit lets |-2^(W-1)| be held exactly.
    assign dvd_ext = {bus.dividend[DIVIDEND_W-1], bus.dividend};
    assign dsr_ext = {bus.divisor[DIVISOR_W-1], bus.divisor};

    // After DIVIDEND_W shifts the low bits hold the quotient; the top bit is stale.
    assign qmag = DIVIDEND_W'(dvd_reg);
    assign rmag = DIVISOR_W'(prem_reg);

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem      (prem_reg),
        .next_bit (dvd_reg[DIVIDEND_W-1]),
        .dmag     (dmag_reg),
        .rem_out  (step_rem),
        .q_bit    (step_q)
    );

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        dvd_next    = dvd_reg;
        dmag_next   = dmag_reg;
        prem_next   = prem_reg;
        sign_q_next = sign_q_reg;
        sign_r_next = sign_r_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        quot_next   = quot_reg;
        rem_next    = rem_reg;
        dbz_next    = dbz_reg;
        ovf_next    = ovf_reg;

        case (state_reg)
            IDLE: begin
                // The cycle done is high is still IDLE; a start there is dropped.
                if (bus.start && !done_reg) begin
                    dvd_next    = dvd_ext[DIVIDEND_W] ? -dvd_ext : dvd_ext;
                    dmag_next   = dsr_ext[DIVISOR_W] ? -dsr_ext : dsr_ext;
                    prem_next   = '0;
                    sign_q_next = bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
                    sign_r_next = bus.dividend[DIVIDEND_W-1];
                    cnt_next    = '0;
                    busy_next   = 1'b1;
                    dbz_next    = 1'b0;
                    ovf_next    = 1'b0;
                    if (bus.divisor == '0) begin
                        quot_next  = '0;
                        rem_next   = '0;
                        dbz_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                dvd_next  = {dvd_reg[DIVIDEND_W-1:0], step_q};
                prem_next = step_rem;
                cnt_next  = cnt_reg + 1'b1;
                if (cnt_reg == CW'(DIVIDEND_W-1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                quot_next  = sign_q_reg ? -qmag : qmag;
                rem_next   = sign_r_reg ? -rmag : rmag;
                ovf_next   = (qmag == Q_MIN) && !sign_q_reg;
                state_next = DONE;
            end
            DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            dvd_reg    <= '0;
            dmag_reg   <= '0;
            prem_reg   <= '0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            quot_reg   <= '0;
            rem_reg    <= '0;
            dbz_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            dvd_reg    <= dvd_next;
            dmag_reg   <= dmag_next;
            prem_reg   <= prem_next;
            sign_q_reg <= sign_q_next;
            sign_r_reg <= sign_r_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            quot_reg   <= quot_next;
            rem_reg    <= rem_next;
            dbz_reg    <= dbz_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.quotient    = quot_reg;
    assign bus.remainder   = rem_reg;
    assign bus.div_by_zero = dbz_reg;
    assign bus.overflow    = ovf_reg;
endmodule

// File: tb/tb_signed_sequential_divider.sv
// Randomised and directed scoreboard bench for the signed sequential divider.
module tb_signed_sequential_divider;

    typedef struct {
        logic [5:0] q;
        logic [2:0] r;
        logic       dbz;
        logic       ovf;
        int         cyc;
        int         a;
        int         d;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   passes;
    int   dones_seen;
    int   dones_expected;
    exp_t sb[$];

    signed_sequential_divider_if bus_if ();

    signed_sequential_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    // Reference: integer division truncates toward zero, % takes the dividend's sign.
    function automatic exp_t model(input int a, input int d, input int acc_cyc);
        exp_t e;
        int   qi;
        int   ri;
        e.a = a;
        e.d = d;
        if (d == 0) begin
            e.q = 6'd0; e.r = 3'd0; e.dbz = 1'b1; e.ovf = 1'b0;
            e.cyc = acc_cyc + 1;
        end else begin
            qi = a / d;
            ri = a % d;
            e.q = qi[5:0];
            e.r = ri[2:0];
            e.dbz = 1'b0;
            e.ovf = (qi > 31);
            e.cyc = acc_cyc + 8;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus_if.done) begin
            dones_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("op %0d / %0d -> q=%0d r=%0d dbz=%0b ovf=%0b (exp q=%0d r=%0d)",
                         e.a, e.d, $signed(bus_if.quotient), $signed(bus_if.remainder),
                         bus_if.div_by_zero, bus_if.overflow, $signed(e.q), $signed(e.r));
                check("quotient",    int'(bus_if.quotient),    int'(e.q));
                check("remainder",   int'(bus_if.remainder),   int'(e.r));
                check("div_by_zero", int'(bus_if.div_by_zero), int'(e.dbz));
                check("overflow",    int'(bus_if.overflow),    int'(e.ovf));
                check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the following negedge with start low.
    task automatic drive_start(input int a, input int d);
        bus_if.dividend = a[5:0];
        bus_if.divisor  = d[2:0];
        bus_if.start    = 1'b1;
        @(negedge clk);
        bus_if.start    = 1'b0;
        bus_if.dividend = 6'($urandom);
        bus_if.divisor  = 3'($urandom);
    endtask

    task automatic issue(input int a, input int d);
        sb.push_back(model(a, d, cyc + 1));
        dones_expected++;
        drive_start(a, d);
    endtask

    task automatic wait_done();
        bit busy_ok;
        bit seen;
        busy_ok = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.done) begin
                seen = 1'b1;
                break;
            end
            if (!bus_if.busy) busy_ok = 1'b0;
            @(negedge clk);
        end
        check("done_within_bound", int'(seen), 1);
        check("busy_held_until_done", int'(busy_ok), 1);
        if (seen) begin
            check("busy_low_with_done", int'(bus_if.busy), 0);
            @(negedge clk);
            check("done_one_cycle", int'(bus_if.done), 0);
        end
    endtask

    task automatic run(input int a, input int d);
        issue(a, d);
        wait_done();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},      int'(bus_if.busy),        0);
        check({tag, "_done"},      int'(bus_if.done),        0);
        check({tag, "_quotient"},  int'(bus_if.quotient),    0);
        check({tag, "_remainder"}, int'(bus_if.remainder),   0);
        check({tag, "_dbz"},       int'(bus_if.div_by_zero), 0);
        check({tag, "_ovf"},       int'(bus_if.overflow),    0);
    endtask

    initial begin
        checks = 0; passes = 0; dones_seen = 0; dones_expected = 0;
        rst_n = 1'b0;
        bus_if.start = 1'b0;
        bus_if.dividend = '0;
        bus_if.divisor = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run(13, 3);
        run(-13, 3);
        run(13, -4);
        run(-32, -1);
        run(-32, 1);
        run(7, 0);
        run(6, 2);
        run(31, -4);
        run(-32, 3);

        // A second start mid-operation must be ignored entirely.
        issue(13, 3);
        repeat (2) @(negedge clk);
        bus_if.dividend = 6'd1;
        bus_if.divisor  = 3'd1;
        bus_if.start    = 1'b1;
        @(negedge clk);
        bus_if.start    = 1'b0;
        wait_done();

        // Start held high across done: only the first request is accepted.
        issue(20, 3);
        bus_if.start = 1'b1;
        bus_if.dividend = 6'd9;
        bus_if.divisor  = 3'd2;
        wait_done();
        bus_if.start = 1'b0;
        @(negedge clk);

        // Reset mid-CALC abandons the operation.
        drive_start(13, 3);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("after_reset_idle_busy", int'(bus_if.busy), 0);
        run(5, 2);

        for (int n = 0; n < 40; n++) begin
            int a;
            int d;
            a = int'($urandom_range(0, 63)) - 32;
            d = int'($urandom_range(0, 7)) - 4;
            run(a, d);
        end

        repeat (4) @(negedge clk);
        check("done_pulse_count", dones_seen, dones_expected);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/signed_sequential_divider.md
Name: signed_sequential_divider

Overview:
- Iterative signed divider; the inverse operation to the team's 3-bit signed array multiplier.
- Takes a 6-bit two's-complement dividend (multiplier product width) and a 3-bit two's-complement divisor.
- Returns quotient and remainder using a start/busy/done handshake.
- Uses restoring division on magnitudes, one quotient bit per clock, then a sign fix-up. Sits beside the multiplier in the arithmetic lab datapath.

Parameters:
- DIVIDEND_W, 6, dividend and quotient width (two's complement).
- DIVISOR_W, 3, divisor and remainder width (two's complement).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  DIVIDEND_W  signed dividend, sampled with start.
- divisor  input  DIVISOR_W  signed divisor, sampled with start.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  DIVIDEND_W  signed quotient, truncated toward zero.
- remainder  output  DIVISOR_W  signed remainder; sign follows the dividend.
- div_by_zero  output  1  divisor was 0 for the last operation.
- overflow  output  1  true quotient is not representable (only min/-1).

Behaviour:
- Decided: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset, asserted at any time including mid-operation:
  - State goes to IDLE.
  - busy, done, quotient, remainder, div_by_zero and overflow are all 0.
  - Any operation in progress is abandoned.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - If start=1 at a rising edge, capture the operands. Store |dividend| in a DIVIDEND_W+1 bit register and |divisor| in DIVISOR_W+1 bits.
  - Record sign_q = sign(dividend) XOR sign(divisor), and sign_r = sign(dividend).
  - Clear the step counter, set busy=1 and clear div_by_zero and overflow.
  - Next state is CALC, or DONE if divisor==0.
- CALC, one iteration per cycle, exactly DIVIDEND_W cycles:
  - Shift the {partial remainder, dividend} pair left by 1.
  - Trial-subtract |divisor|. If the result is non-negative, keep it and set quotient bit 1; otherwise restore and set quotient bit 0.
  - The counter runs 0..DIVIDEND_W-1; on the last count go to FIX.
- FIX:
  - Negate the magnitude quotient if sign_q=1, and the magnitude remainder if sign_r=1.
  - overflow=1 iff the magnitude quotient is 2^(DIVIDEND_W-1) and sign_q=0. The quotient output is then the wrapped value 100000.
  - Load the output registers and go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, and return to IDLE.
- Latency:
  - Start sampled at edge k puts done high after edge k+DIVIDEND_W+2 (k+8 by default).
  - Divide-by-zero puts done high after edge k+1.
- Divide-by-zero result: quotient=0, remainder=0, div_by_zero=1, overflow=0.
- Outputs quotient, remainder, div_by_zero and overflow hold their values until the next accepted start.
- start while busy or in DONE is ignored, not queued. A start in the same cycle that done is high is ignored.
- Operand inputs may change freely after acceptance.
- Width rule: the remainder magnitude is always < |divisor| ≤ 4, so it fits in DIVISOR_W signed bits.
- Magnitude of the most negative dividend (-32) is held in the DIVIDEND_W+1 bit register without loss.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package arith_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - DIVIDEND_W/DIVISOR_W defaults;
  - the counter width constant, $clog2(DIVIDEND_W)+1.
- One natural sub-module: div_step. It is a combinational single restoring step: inputs are partial remainder, next dividend bit and divisor magnitude; outputs are the new partial remainder and the quotient bit.
- The top level owns the FSM, registers and sign fix-up.

Test Plan:
- 13 / 3 -> after 8 cycles done=1, quotient=000100 (4), remainder=001 (1), overflow=0, div_by_zero=0.
- -13 / 3 -> quotient=111100 (-4), remainder=111 (-1); 13 / -4 -> quotient=111101 (-3), remainder=001 (1).
- -32 / -1 -> quotient=100000, remainder=000, overflow=1; -32 / 1 -> quotient=100000, overflow=0.
- 7 / 0 -> done after 2 edges, div_by_zero=1, quotient=0, remainder=0; a following 6/2 clears the flag, giving quotient=3.
- start pulsed again at cycle 3 of 13/3 with operands 1/1 -> ignored; result is still 4 r1, busy stays continuously high, and exactly one done pulse occurs.
- rst_n dropped at CALC cycle 4 then released -> all outputs 0, state IDLE; a new start 5/2 gives quotient=2, remainder=1 with standard latency.
